// File: rtl/dma_pkg.sv
// Shared types and helpers for the DMA line reader slice.
package dma_pkg;

    // Read-master sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } dma_rd_state_t;

    // Default geometry of the line reader
    localparam int DMA_ADDR_W     = 32;
    localparam int DMA_DATA_W     = 32;
    localparam int DMA_LEN_W      = 16;
    localparam int DMA_FIFO_DEPTH = 16;

    // Byte address increment between consecutive words of a line
    function automatic int word_bytes(input int data_w);
        return data_w / 8;
    endfunction

    // Width of a counter able to hold every value from 0 up to depth inclusive
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous FIFO with a registered output stage and an occupancy count.
// The output register is part of the capacity, so count covers every word held.
// A write into an empty FIFO lands directly in the output register, giving one
// cycle from write to rd_valid.
module dma_sync_fifo
    import dma_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic                          rd_en,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    output logic [count_width(DEPTH)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] mem_count;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;

    logic pop;
    logic load_slot;
    logic load_from_mem;
    logic bypass;
    logic mem_write;

    // Decide where an incoming word goes and whether the output stage refills
    always_comb begin
        pop           = rd_en && out_valid;
        load_slot     = !out_valid || pop;
        load_from_mem = load_slot && (mem_count != '0);
        bypass        = load_slot && (mem_count == '0) && wr_en;
        mem_write     = wr_en && !bypass && (mem_count != CNT_W'(DEPTH));
    end

    // Pointers, storage occupancy and the registered output word
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mem_count <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (mem_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (load_from_mem) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({mem_write, load_from_mem})
                2'b10:   mem_count <= mem_count + CNT_W'(1);
                2'b01:   mem_count <= mem_count - CNT_W'(1);
                default: mem_count <= mem_count;
            endcase
            if (load_from_mem) begin
                out_data  <= mem[rd_ptr];
                out_valid <= 1'b1;
            end else if (bypass) begin
                out_data  <= wr_data;
                out_valid <= 1'b1;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Storage array write port; contents need no reset since occupancy guards reads
    always_ff @(posedge clk) begin
        if (mem_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data  = out_data;
    assign rd_valid = out_valid;
    assign count    = mem_count + CNT_W'(out_valid);

endmodule

// File: rtl/dma_line_reader.sv
// Avalon-MM read master that fetches one scan line per enable and streams it
// out as a single Avalon-ST packet. Reads are throttled by a credit rule so the
// words in flight plus the words buffered never exceed the FIFO depth.
module dma_line_reader
    import dma_pkg::*;
#(
    parameter int ADDR_W     = DMA_ADDR_W,
    parameter int DATA_W     = DMA_DATA_W,
    parameter int LEN_W      = DMA_LEN_W,
    parameter int FIFO_DEPTH = DMA_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dma_transmit_on,
    input  logic [ADDR_W-1:0] cfg_base_addr,
    input  logic [LEN_W-1:0]  cfg_line_words,
    output logic [ADDR_W-1:0] avm_m0_address,
    output logic              avm_m0_read,
    input  logic              avm_m0_waitrequest,
    input  logic [DATA_W-1:0] avm_m0_readdata,
    input  logic              avm_m0_readdatavalid,
    output logic [DATA_W-1:0] aso_out0_data,
    output logic              aso_out0_valid,
    input  logic              aso_out0_ready,
    output logic              aso_out0_startofpacket,
    output logic              aso_out0_endofpacket,
    output logic              busy,
    output logic              line_done
);

    localparam int                CNT_W     = count_width(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(word_bytes(DATA_W));

    dma_rd_state_t state;
    dma_rd_state_t next_state;

    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  issue_left;
    logic [LEN_W-1:0]  out_left;
    logic [CNT_W-1:0]  pending;
    logic              first_word;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    in_flight;
    logic              credit_ok;
    logic              start;
    logic              accept;
    logic              pop;
    logic              last_issue;
    logic              line_complete;

    // Credit, handshake and completion terms shared by the FSM and counters
    always_comb begin
        in_flight     = {1'b0, pending} + {1'b0, fifo_count};
        credit_ok     = in_flight < (CNT_W + 1)'(FIFO_DEPTH);
        start         = dma_transmit_on && (cfg_line_words != '0);
        accept        = avm_m0_read && !avm_m0_waitrequest;
        pop           = aso_out0_valid && aso_out0_ready;
        last_issue    = issue_left == LEN_W'(1);
        line_complete = (pending == '0) && (out_left == '0);
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state selection: start a line, finish issuing, then wait for the drain
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                if (accept && last_issue) begin
                    next_state = DRAIN;
                end
            end
            DRAIN: begin
                if (line_complete) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State-decoded outputs; the read request depends only on registered state
    // and credit, so it stays put while the slave stalls
    always_comb begin
        avm_m0_read = 1'b0;
        busy        = 1'b0;
        line_done   = 1'b0;
        case (state)
            ISSUE: begin
                busy        = 1'b1;
                avm_m0_read = credit_ok;
            end
            DRAIN: begin
                busy      = 1'b1;
                line_done = line_complete;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Address, issue/output length counters and the first-word marker
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr       <= '0;
            issue_left <= '0;
            out_left   <= '0;
            first_word <= 1'b0;
        end else if (state == IDLE && start) begin
            addr       <= cfg_base_addr;
            issue_left <= cfg_line_words;
            out_left   <= cfg_line_words;
            first_word <= 1'b1;
        end else begin
            if (accept) begin
                addr       <= addr + ADDR_STEP;
                issue_left <= issue_left - LEN_W'(1);
            end
            if (pop) begin
                out_left   <= out_left - LEN_W'(1);
                first_word <= 1'b0;
            end
        end
    end

    // Reads accepted by the slave but whose data has not yet come back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            case ({accept, avm_m0_readdatavalid})
                2'b10:   pending <= pending + CNT_W'(1);
                2'b01:   pending <= pending - CNT_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    dma_sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (avm_m0_readdatavalid),
        .wr_data  (avm_m0_readdata),
        .rd_en    (aso_out0_ready),
        .rd_data  (aso_out0_data),
        .rd_valid (aso_out0_valid),
        .count    (fifo_count)
    );

    assign avm_m0_address         = addr;
    assign aso_out0_startofpacket = aso_out0_valid && first_word;
    assign aso_out0_endofpacket   = aso_out0_valid && (out_left == LEN_W'(1));

endmodule

// File: tb/tb_dma_line_reader.sv
// Directed bench for dma_line_reader with a one-cycle-latency memory model.
module tb_dma_line_reader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dma_transmit_on = 1'b0;
    logic [31:0] cfg_base_addr = 32'h0;
    logic [15:0] cfg_line_words = 16'h0;
    logic [31:0] avm_m0_address;
    logic        avm_m0_read;
    logic        avm_m0_waitrequest;
    logic [31:0] avm_m0_readdata;
    logic        avm_m0_readdatavalid;
    logic [31:0] aso_out0_data;
    logic        aso_out0_valid;
    logic        aso_out0_ready = 1'b0;
    logic        aso_out0_startofpacket;
    logic        aso_out0_endofpacket;
    logic        busy;
    logic        line_done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int rel_cyc = 0;
    int max_out = 0;
    int stall_cnt = 0;
    int stall_limit = 0;
    int stall_seen = 0;
    int busy_cnt = 0;
    int snap = 0;
    logic [31:0] stall_addr = 32'h0;

    logic [31:0] rd_addr_q[$];
    int          rd_cyc_q[$];
    logic [31:0] st_data_q[$];
    logic        st_sop_q[$];
    logic        st_eop_q[$];
    int          st_cyc_q[$];
    int          ld_cyc_q[$];

    dma_line_reader dut (
        .clk                    (clk),
        .reset                  (reset),
        .dma_transmit_on        (dma_transmit_on),
        .cfg_base_addr          (cfg_base_addr),
        .cfg_line_words         (cfg_line_words),
        .avm_m0_address         (avm_m0_address),
        .avm_m0_read            (avm_m0_read),
        .avm_m0_waitrequest     (avm_m0_waitrequest),
        .avm_m0_readdata        (avm_m0_readdata),
        .avm_m0_readdatavalid   (avm_m0_readdatavalid),
        .aso_out0_data          (aso_out0_data),
        .aso_out0_valid         (aso_out0_valid),
        .aso_out0_ready         (aso_out0_ready),
        .aso_out0_startofpacket (aso_out0_startofpacket),
        .aso_out0_endofpacket   (aso_out0_endofpacket),
        .busy                   (busy),
        .line_done              (line_done)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to timestamp observed events
    always @(posedge clk) cyc <= cyc + 1;

    // Memory content as seen by the reader: every word is its address plus an offset
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h1111_0000;
    endfunction

    // Slave stalls a chosen address for a programmable number of cycles
    assign avm_m0_waitrequest = avm_m0_read && (avm_m0_address == stall_addr) && (stall_cnt < stall_limit);

    // Count stall cycles consumed by the slave
    always @(posedge clk) if (avm_m0_waitrequest) stall_cnt <= stall_cnt + 1;

    // Memory slave answering each accepted read one cycle later
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            avm_m0_readdatavalid <= 1'b0;
            avm_m0_readdata      <= 32'h0;
        end else begin
            avm_m0_readdatavalid <= avm_m0_read && !avm_m0_waitrequest;
            avm_m0_readdata      <= mem_word(avm_m0_address);
        end
    end

    // Monitor on the falling edge: log accepted reads, accepted stream words and pulses
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_m0_read && !avm_m0_waitrequest) begin
                rd_addr_q.push_back(avm_m0_address);
                rd_cyc_q.push_back(cyc);
            end
            if (avm_m0_read && avm_m0_waitrequest && avm_m0_address == stall_addr)
                stall_seen <= stall_seen + 1;
            if (aso_out0_valid && aso_out0_ready) begin
                st_data_q.push_back(aso_out0_data);
                st_sop_q.push_back(aso_out0_startofpacket);
                st_eop_q.push_back(aso_out0_endofpacket);
                st_cyc_q.push_back(cyc);
            end
            if (line_done) ld_cyc_q.push_back(cyc);
            if (busy) busy_cnt <= busy_cnt + 1;
        end
    end

    // Hard stop so a stuck design still ends the run
    initial begin
        #400000;
        $display("[TB] FAIL watchdog observed=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic [31:0] base, input logic [15:0] len);
        @(posedge clk); #1;
        dma_transmit_on = en;
        cfg_base_addr   = base;
        cfg_line_words  = len;
        start_cyc       = cyc;
    endtask

    task automatic tick();
        @(posedge clk); #2;
        if (rd_addr_q.size() - st_data_q.size() > max_out)
            max_out = rd_addr_q.size() - st_data_q.size();
    endtask

    task automatic clear_monitors();
        rd_addr_q.delete(); rd_cyc_q.delete();
        st_data_q.delete(); st_sop_q.delete(); st_eop_q.delete(); st_cyc_q.delete();
        ld_cyc_q.delete();
    endtask

    task automatic start_line(input logic [31:0] base, input logic [15:0] len, input bit hold);
        applyStimulus(1'b1, base, len);
        if (!hold) begin
            @(posedge clk); #1;
            dma_transmit_on = 1'b0;
        end
    endtask

    task automatic wait_done(input int n, input int budget);
        for (int i = 0; i < budget && ld_cyc_q.size() < n; i++) tick();
        checkOutput("line_done_count", ld_cyc_q.size(), n);
    endtask

    task automatic wait_reads(input int n, input int budget);
        for (int i = 0; i < budget && rd_addr_q.size() < n; i++) tick();
        checkOutput("reads_reached", rd_addr_q.size() >= n, 1);
    endtask

    task automatic check_stream(input string tag, input logic [31:0] base, input int len, input int lines);
        int total;
        int j;
        total = len * lines;
        checkOutput({tag, "_reads"}, rd_addr_q.size(), total);
        checkOutput({tag, "_words"}, st_data_q.size(), total);
        for (int i = 0; i < total; i++) begin
            j = i % len;
            if (i < rd_addr_q.size())
                checkOutput($sformatf("%s_addr%0d", tag, i), rd_addr_q[i], base + 32'(4 * j));
            if (i < st_data_q.size()) begin
                checkOutput($sformatf("%s_data%0d", tag, i), st_data_q[i], mem_word(base + 32'(4 * j)));
                checkOutput($sformatf("%s_sop%0d", tag, i), st_sop_q[i], j == 0);
                checkOutput($sformatf("%s_eop%0d", tag, i), st_eop_q[i], j == len - 1);
            end
        end
    endtask

    initial begin
        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", {26'b0, avm_m0_read, aso_out0_valid, aso_out0_startofpacket,
                                    aso_out0_endofpacket, busy, line_done}, 32'h0);
        checkOutput("reset_addr", avm_m0_address, 32'h0);
        checkOutput("reset_data", aso_out0_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) tick();
        checkOutput("idle_busy", busy, 1'b0);

        $display("[TB] basic line");
        aso_out0_ready = 1'b1;
        clear_monitors();
        start_line(32'h1000, 16'd4, 1'b0);
        wait_done(1, 40);
        check_stream("basic", 32'h1000, 4, 1);
        checkOutput("basic_addr3", rd_addr_q[3], 32'h0000_100C);
        checkOutput("basic_first_read", rd_cyc_q[0], start_cyc + 1);
        checkOutput("basic_back_to_back", rd_cyc_q[3] - rd_cyc_q[0], 3);
        checkOutput("basic_out_latency", st_cyc_q[0], rd_cyc_q[0] + 2);
        checkOutput("basic_done_time", ld_cyc_q[0], st_cyc_q[3] + 1);
        repeat (5) tick();
        checkOutput("basic_single_pulse", ld_cyc_q.size(), 1);

        $display("[TB] waitrequest");
        clear_monitors();
        @(posedge clk); #1;
        stall_addr  = 32'h1004;
        stall_limit = stall_cnt + 3;
        snap        = stall_seen;
        start_line(32'h1000, 16'd4, 1'b0);
        wait_done(1, 40);
        checkOutput("stall_cycles", stall_seen - snap, 3);
        checkOutput("stall_gap", rd_cyc_q[1] - rd_cyc_q[0], 4);
        check_stream("stall", 32'h1000, 4, 1);

        $display("[TB] backpressure");
        clear_monitors();
        @(posedge clk); #1;
        aso_out0_ready = 1'b0;
        max_out = 0;
        start_line(32'h2000, 16'd40, 1'b0);
        repeat (40) tick();
        checkOutput("bp_reads_stop", rd_addr_q.size(), 16);
        checkOutput("bp_max_outstanding", max_out, 16);
        checkOutput("bp_busy", busy, 1'b1);
        checkOutput("bp_valid_held", aso_out0_valid, 1'b1);
        checkOutput("bp_data_held", aso_out0_data, 32'h1111_2000);
        checkOutput("bp_sop_held", aso_out0_startofpacket, 1'b1);
        @(posedge clk); #1;
        aso_out0_ready = 1'b1;
        wait_done(1, 200);
        checkOutput("bp_credit_bound", max_out <= 16, 1);
        check_stream("bp", 32'h2000, 40, 1);

        $display("[TB] enable drop");
        clear_monitors();
        start_line(32'h6000, 16'd8, 1'b1);
        for (int i = 0; i < 30 && st_data_q.size() < 2; i++) tick();
        dma_transmit_on = 1'b0;
        wait_done(1, 60);
        repeat (20) tick();
        checkOutput("drop_no_restart", busy, 1'b0);
        check_stream("drop", 32'h6000, 8, 1);
        checkOutput("drop_one_line", ld_cyc_q.size(), 1);

        $display("[TB] continuous mode");
        clear_monitors();
        start_line(32'h7000, 16'd3, 1'b1);
        wait_reads(7, 60);
        dma_transmit_on = 1'b0;
        wait_done(3, 100);
        repeat (20) tick();
        check_stream("cont", 32'h7000, 3, 3);
        checkOutput("cont_lines", ld_cyc_q.size(), 3);
        checkOutput("cont_gap1", rd_cyc_q[3], ld_cyc_q[0] + 2);
        checkOutput("cont_gap2", rd_cyc_q[6], ld_cyc_q[1] + 2);

        $display("[TB] zero length");
        clear_monitors();
        snap = busy_cnt;
        applyStimulus(1'b1, 32'h8000, 16'd0);
        repeat (10) tick();
        dma_transmit_on = 1'b0;
        checkOutput("len0_busy", busy_cnt - snap, 0);
        checkOutput("len0_reads", rd_addr_q.size(), 0);

        $display("[TB] single word");
        clear_monitors();
        start_line(32'h3000, 16'd1, 1'b0);
        wait_done(1, 30);
        check_stream("len1", 32'h3000, 1, 1);

        $display("[TB] address wrap");
        clear_monitors();
        start_line(32'hFFFF_FFFC, 16'd2, 1'b0);
        wait_done(1, 30);
        check_stream("wrap", 32'hFFFF_FFFC, 2, 1);
        checkOutput("wrap_to_zero", rd_addr_q[1], 32'h0);

        $display("[TB] reset mid-line");
        clear_monitors();
        start_line(32'h4000, 16'd8, 1'b1);
        wait_reads(3, 20);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        checkOutput("rst_mid_flags", {26'b0, avm_m0_read, aso_out0_valid, aso_out0_startofpacket,
                                      aso_out0_endofpacket, busy, line_done}, 32'h0);
        checkOutput("rst_mid_addr", avm_m0_address, 32'h0);
        checkOutput("rst_mid_data", aso_out0_data, 32'h0);
        cfg_base_addr  = 32'h5000;
        cfg_line_words = 16'd3;
        repeat (2) @(posedge clk);
        #1;
        clear_monitors();
        reset   = 1'b0;
        rel_cyc = cyc;
        wait_reads(1, 10);
        dma_transmit_on = 1'b0;
        wait_done(1, 40);
        checkOutput("rst_restart_time", rd_cyc_q[0], rel_cyc + 1);
        check_stream("rst", 32'h5000, 3, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
